// File: rtl/ff_inv4_seq_pkg.sv
// Shared constants for the GF(2^4) inverter: field width, reduction polynomial
// and the sequencer state encoding.
package ff_inv4_seq_pkg;

    localparam int unsigned GF_W = 4;
    localparam logic [GF_W:0] GF_POLY = 5'h13;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M1   = 3'd1,
        S_M2   = 3'd2,
        S_M3   = 3'd3,
        S_M4   = 3'd4,
        S_M5   = 3'd5,
        S_DONE = 3'd6
    } state_t;

endpackage

// File: rtl/FFMul_K4_Q2.sv
// Combinational GF(2^4) multiplier, field polynomial x^4+x+1.
module FFMul_K4_Q2
    import ff_inv4_seq_pkg::*;
(
    input  logic [GF_W-1:0] a,
    input  logic [GF_W-1:0] b,
    output logic [GF_W-1:0] p
);

    logic [GF_W-1:0] sh;

    // Shift-and-add: sh walks a*x^i, reduced each step so it never grows.
    always_comb begin
        p  = '0;
        sh = a;
        for (int i = 0; i < int'(GF_W); i++) begin
            if (b[i]) begin
                p = p ^ sh;
            end
            sh = {sh[GF_W-2:0], 1'b0} ^ (sh[GF_W-1] ? GF_POLY[GF_W-1:0] : GF_W'(0));
        end
    end

endmodule

// File: rtl/ff_inv4_seq.sv
// GF(2^4) inverter: out = a^14 via one shared multiplier sequenced over
// five cycles (a^2, a^4, a^6, a^8, a^14), with valid/ready on both sides.
module ff_inv4_seq
    import ff_inv4_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [GF_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [GF_W-1:0] out_data,
    output logic            busy
);

    state_t          state, state_n;
    logic [GF_W-1:0] a_q, t_q, u_q, r_q;
    logic [GF_W-1:0] a_n, t_n, u_n, r_n;
    logic [GF_W-1:0] mul_x, mul_y, mul_p;

    FFMul_K4_Q2 u_mul (
        .a (mul_x),
        .b (mul_y),
        .p (mul_p)
    );

    // Next state, operand select and writeback, all keyed on the current state.
    always_comb begin
        state_n = state;
        a_n     = a_q;
        t_n     = t_q;
        u_n     = u_q;
        r_n     = r_q;
        mul_x   = '0;
        mul_y   = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    a_n     = in_data;
                    state_n = S_M1;
                end
            end
            S_M1: begin
                mul_x   = a_q;
                mul_y   = a_q;
                t_n     = mul_p;
                state_n = S_M2;
            end
            S_M2: begin
                mul_x   = t_q;
                mul_y   = t_q;
                u_n     = mul_p;
                state_n = S_M3;
            end
            S_M3: begin
                mul_x   = t_q;
                mul_y   = u_q;
                r_n     = mul_p;
                state_n = S_M4;
            end
            S_M4: begin
                mul_x   = u_q;
                mul_y   = u_q;
                u_n     = mul_p;
                state_n = S_M5;
            end
            S_M5: begin
                mul_x   = r_q;
                mul_y   = u_q;
                r_n     = mul_p;
                state_n = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            a_q       <= '0;
            t_q       <= '0;
            u_q       <= '0;
            r_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            a_q       <= a_n;
            t_q       <= t_n;
            u_q       <= u_n;
            r_q       <= r_n;
            in_ready  <= (state_n == S_IDLE);
            out_valid <= (state_n == S_DONE);
            out_data  <= (state_n == S_DONE) ? r_n : GF_W'(0);
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ff_inv4_seq.sv
// Directed bench for ff_inv4_seq: latency, inverse values, back-pressure,
// busy drop, mid-operation reset and back-to-back issue.
module tb_ff_inv4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ff_inv4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Independent reference: carry-less product then polynomial long division.
    function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] prod;
        prod = '0;
        for (int i = 0; i < 4; i++)
            if (y[i]) prod = prod ^ (7'(x) << i);
        for (int j = 6; j >= 4; j--)
            if (prod[j]) prod = prod ^ (7'h13 << (j - 4));
        return prod[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 4'd0)  begin bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int early;
        early = 0;
        in_data = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) early++;
            tick();
        end
        total++; if (early != 0) begin bad++; $display("FAIL basic_busy_window got=%0d bad_cycles exp=0", early); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency6 got=%b exp=1", out_valid); end
        total++; if (out_data !== 4'd9)  begin bad++; $display("FAIL basic_data got=%0d exp=9", out_data); end
        tick();
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL basic_ready_after got=%b exp=1", in_ready); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        logic [3:0] va [4] = '{4'd0, 4'd1, 4'd5, 4'd8};
        logic [3:0] ve [4] = '{4'd0, 4'd1, 4'd11, 4'd15};
        int lat;
        int inv_bad;
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_data = va[n]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0; lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
            total++; if (lat != 6) begin bad++; $display("FAIL sweep_latency a=%0d got=%0d exp=6", va[n], lat); end
            total++; if (out_data !== ve[n]) begin bad++; $display("FAIL sweep_data a=%0d got=%0d exp=%0d", va[n], out_data, ve[n]); end
            tick();
        end
        inv_bad = 0;
        for (int a = 1; a < 16; a++) begin
            in_data = 4'(a); in_valid = 1'b1;
            tick();
            in_valid = 1'b0; lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
            if (lat != 6 || gf_mul(4'(a), out_data) !== 4'd1) begin
                inv_bad++;
                $display("FAIL sweep_inverse a=%0d got=%0d lat=%0d product=%0d exp_product=1", a, out_data, lat, gf_mul(4'(a), out_data));
            end
            tick();
        end
        total++; if (inv_bad != 0) bad++;
    endtask

    task automatic test_backpressure();
        int lat;
        int held_bad;
        out_ready = 1'b0; in_data = 4'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        total++; if (lat != 6) begin bad++; $display("FAIL bp_latency got=%0d exp=6", lat); end
        held_bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 4'd11) begin
                held_bad++;
                $display("FAIL bp_hold cycle=%0d got_valid=%b got_data=%0d exp=1/11", k, out_valid, out_data);
            end
        end
        total++; if (held_bad != 0) bad++;
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got_valid=%b got_ready=%b exp=0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_drop();
        int lat;
        out_ready = 1'b1; in_data = 4'd2; in_valid = 1'b1;
        tick();
        in_data = 4'd8;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL drop_in_ready got=%b exp=0", in_ready); end
        tick(); tick();
        in_valid = 1'b0; lat = 3;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        total++; if (lat != 6) begin bad++; $display("FAIL drop_latency got=%0d exp=6", lat); end
        total++; if (out_data !== 4'd9) begin bad++; $display("FAIL drop_data got=%0d exp=9", out_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int spur;
        out_ready = 1'b1; in_data = 4'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs got=%b%b%0d%b exp=1000", in_ready, out_valid, out_data, busy);
        end
        spur = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid !== 1'b0) spur++;
            tick();
        end
        total++; if (spur != 0) begin bad++; $display("FAIL midrst_no_valid got=%0d exp=0", spur); end
        in_data = 4'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        total++; if (lat != 6 || out_data !== 4'd9) begin
            bad++; $display("FAIL midrst_next got_lat=%0d got_data=%0d exp=6/9", lat, out_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc [$];
        logic [3:0] res [$];
        out_ready = 1'b1; in_data = 4'd2; in_valid = 1'b1;
        for (int k = 0; k < 40 && res.size() < 2; k++) begin
            if (in_valid && in_ready === 1'b1) begin
                acc.push_back(cyc);
                if (acc.size() == 2) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    continue;
                end
            end
            if (out_valid === 1'b1) res.push_back(out_data);
            @(posedge clk); #1;
            if (acc.size() == 1) in_data = 4'd8;
        end
        total++; if (res.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", res.size());
        end else begin
            total++; if (res[0] !== 4'd9)  begin bad++; $display("FAIL b2b_first got=%0d exp=9", res[0]); end
            total++; if (res[1] !== 4'd15) begin bad++; $display("FAIL b2b_second got=%0d exp=15", res[1]); end
        end
        total++; if (acc.size() != 2 || acc[1] - acc[0] != 7) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=7", (acc.size() == 2) ? acc[1] - acc[0] : -1);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_backpressure();
        test_busy_drop();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_inv4_seq.md
FF_INV4_SEQ -- requirements
Module: ff_inv4_seq

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset; ports clk and rst.
REQ-002 SHALL expose ports as listed (name  direction  width  meaning):
  clk  input  1  rising-edge clock
  rst  input  1  synchronous active-high reset
  in_valid  input  1  operand offered
  in_ready  output  1  block can accept operand
  in_data  input  4  operand a, GF(2^4) element, polynomial x^4+x+1
  out_valid  output  1  result available
  out_ready  input  1  consumer takes result
  out_data  output  4  a^-1 (0 maps to 0)
  busy  output  1  high in any state other than IDLE

Function
REQ-003 SHALL compute out_data = a^14 (the multiplicative inverse for a != 0, 0 for a = 0) using exactly one shared GF(2^4) multiplier, sequenced over five cycles.
REQ-004 SHALL implement FSM states IDLE, M1, M2, M3, M4, M5, DONE.
REQ-005 In IDLE, in_ready = 1; on in_valid && in_ready SHALL latch in_data into A and go to M1; otherwise stay in IDLE.
REQ-006 Per-state multiplier operands and writeback: M1: T <= A*A (a^2); M2: U <= T*T (a^4); M3: R <= T*U (a^6); M4: U <= U*U (a^8); M5: R <= R*U (a^14); each state advances unconditionally to the next.
REQ-007 M5 SHALL transition to DONE; in DONE out_valid = 1 and out_data = R.
REQ-008 Latency: out_valid SHALL first assert in the 6th cycle after the accepting clock edge; a = 0 SHALL take the same latency.
REQ-009 In DONE with out_ready = 0, SHALL hold out_valid = 1 and out_data stable indefinitely.
REQ-010 In DONE with out_ready = 1, SHALL return to IDLE on that edge; minimum initiation interval is 7 cycles.
REQ-011 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored and SHALL NOT alter A, T, U, or R.
REQ-012 out_data SHALL be 0 whenever out_valid = 0.
REQ-013 Multiplier operand selection SHALL be a pure function of the current state; in IDLE and DONE, multiplier inputs SHALL be driven to 0.
REQ-014 All arithmetic SHALL be 4-bit GF(2^4) arithmetic (XOR add, reduction by 0x13); no carries and no width growth.

Reset
REQ-015 While rst = 1 at a clock edge, the FSM SHALL go to IDLE and A, T, U, R SHALL clear to 0.
REQ-016 Reset values of outputs: in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
REQ-017 rst asserted in any of M1..M5 or DONE SHALL abort the operation, produce no out_valid pulse, and leave the block ready to accept on the first cycle after rst falls.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding (3-bit), the field width constant (4), and the field polynomial constant (0x13).
REQ-019 The block SHALL instantiate the existing combinational GF(2^4) multiplier FFMul_K4_Q2 exactly once as its sole sub-module; no other multiplier logic is allowed.
REQ-020 Operand muxes and writeback enables SHALL be decoded from the state register only; outputs SHALL be registered or decoded from state with no combinational path from in_valid to out_valid.

Verification
REQ-021 After reset, drive in_data = 2 with in_valid = 1 and out_ready = 1 held -> out_valid is high exactly 6 cycles after acceptance with out_data = 9, then in_ready returns the following cycle.
REQ-022 Sweep in_data = 0, 1, 5, 8 -> out_data = 0, 1, 11, 15, each at 6-cycle latency; the bench checks a * out_data = 1 for all 15 nonzero inputs.
REQ-023 Back-pressure: in_data = 5, out_ready = 0 for 10 cycles after DONE -> out_valid stays 1 and out_data stays 11; raising out_ready -> one transfer, then IDLE.
REQ-024 Issue in_data = 8 while busy with a prior operand 2 -> in_ready = 0, the new operand is dropped, and the result is 9.
REQ-025 Assert rst for one cycle during M3 of operand 5 -> no out_valid, outputs at reset values; the next operand 2 yields 9 at normal latency.
REQ-026 Back-to-back operands 2 then 8 with out_ready = 1 -> results 9 and 15, and acceptances are spaced 7 cycles apart.
